axis_wait_burst: RTL and testbench



---
 rtl/axis_wait_pkg.sv | 16 +
 rtl/axis_wait_burst_buf.sv | 27 ++
 rtl/axis_wait_burst.sv | 158 +++++++++++++++
 tb/tb_axis_wait_burst.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_wait_pkg.sv
// Shared types and helpers for the AXI-Stream burst wait stage.
package axis_wait_pkg;

  // Controller states: collect a burst, then release it downstream.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Width of a length field that must hold every value from 0 to depth.
  function automatic int calc_len_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/axis_wait_burst_buf.sv
// Beat storage for one burst: synchronous write, combinational read.
// The data array has no reset; only written entries are ever read.
module wait_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store an accepted upstream beat at the current write slot.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_wait_burst.sv
// AXI-Stream wait stage: after a start command, captures cfg_len beats
// (1..DEPTH) and only then releases them downstream as one burst with
// m_last on the final beat and a done pulse after it.
//
// Handshake rules on both stream ports: a beat moves on a rising edge
// where valid && ready are both high. s_ready is a function of internal
// state only (never of s_valid). Once m_valid rises, m_data and m_valid
// stay constant until the beat is taken by m_ready.
module axis_wait_burst
  import axis_wait_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int LEN_W = calc_len_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_start,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             startAck,
  output logic             err_len,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

  state_t           state_q;
  state_t           state_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] wr_ptr;
  logic [LEN_W-1:0] rd_ptr;
  logic             start_ack_q;
  logic             err_len_q;
  logic             done_q;
  logic             len_ok;
  logic             start_seen;
  logic             start_go;
  logic             s_fire;
  logic             m_fire;
  logic [WIDTH-1:0] rd_data;

  // A start is only looked at in IDLE, and not in the cycle done is high,
  // so a held-over request cannot chain into a new burst unnoticed.
  assign len_ok     = (cfg_len != '0) && (cfg_len <= DEPTH_L);
  assign start_seen = (state_q == IDLE) && ex_start && !done_q;
  assign start_go   = start_seen && len_ok;

  assign s_fire = s_valid && s_ready;
  assign m_fire = m_valid && m_ready;

  // State register; reset aborts any burst in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and stream-side outputs, decoded from the current state.
  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_data  = '0;
    case (state_q)
      IDLE: begin
        if (start_go) begin
          state_d = FILL;
        end
      end
      FILL: begin
        s_ready = (wr_ptr < len_q);
        if (s_valid && s_ready && (wr_ptr == len_q - ONE_L)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        m_valid = 1'b1;
        m_data  = rd_data;
        m_last  = (rd_ptr == len_q - ONE_L);
        if (m_ready && m_last) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Burst length and the write/read pointers into the beat buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (start_go) begin
        len_q  <= cfg_len;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (s_fire) begin
          wr_ptr <= wr_ptr + ONE_L;
        end
        if (m_fire) begin
          rd_ptr <= rd_ptr + ONE_L;
        end
      end
    end
  end

  // One-cycle status pulses, each registered one cycle after its cause.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_ack_q <= 1'b0;
      err_len_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      start_ack_q <= start_go;
      err_len_q   <= start_seen && !len_ok;
      done_q      <= m_fire && m_last;
    end
  end

  assign startAck  = start_ack_q;
  assign err_len   = err_len_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

  wait_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (s_fire),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (s_data),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_axis_wait_burst.sv
// Directed bench for axis_wait_burst: inputs are driven and outputs are
// sampled on the falling clock edge, away from the active edge.
module tb_axis_wait_burst;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int LEN_W = 5;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ex_start = 1'b0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             startAck;
  logic             err_len;
  logic [WIDTH-1:0] s_data = '0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic             m_last;
  logic             busy;
  logic             done;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  axis_wait_burst #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ex_start  (ex_start),
    .cfg_len   (cfg_len),
    .startAck  (startAck),
    .err_len   (err_len),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  int done_cnt = 0;
  logic [WIDTH-1:0] exp_q[$];

  always @(negedge clk) begin
    if (startAck === 1'b1) ack_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [LEN_W-1:0] len);
    ex_start = 1'b1;
    cfg_len  = len;
    @(negedge clk);
    ex_start = 1'b0;
    checks++;
    if (startAck !== 1'b1 || s_ready !== 1'b1 || busy !== 1'b1 || err_len !== 1'b0) begin
      errors++;
      $display("FAIL start_ack len=%0d: startAck=%b s_ready=%b busy=%b err_len=%b, required 1 1 1 0",
               len, startAck, s_ready, busy, err_len);
    end
  endtask

  task automatic fill_beats(input int n, input logic [WIDTH-1:0] base, input bit gaps);
    int sent = 0;
    int cyc = 0;
    logic hs;
    while (sent < n && cyc < 200) begin
      s_valid = gaps ? ((cyc % 3) != 2) : 1'b1;
      s_data  = base + WIDTH'(sent);
      hs = s_valid && s_ready;
      @(negedge clk);
      if (hs) begin
        exp_q.push_back(base + WIDTH'(sent));
        sent++;
      end
      cyc++;
    end
    s_valid = 1'b0;
    s_data  = '0;
    checks++;
    if (sent != n) begin
      errors++;
      $display("FAIL fill_count: accepted %0d beats, required %0d", sent, n);
    end
  endtask

  task automatic drain_beats(input bit toggle);
    int cyc = 0;
    logic hs;
    logic stalled = 1'b0;
    logic [WIDTH-1:0] held = '0;
    checks++;
    if (m_valid !== 1'b1 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL drain_entry: m_valid=%b s_ready=%b, required 1 0", m_valid, s_ready);
    end
    while (exp_q.size() > 0 && cyc < 200) begin
      m_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
      checks++;
      if (m_valid !== 1'b1 || m_data !== exp_q[0]) begin
        errors++;
        $display("FAIL drain_data: m_valid=%b m_data=%h, required 1 %h", m_valid, m_data, exp_q[0]);
      end
      checks++;
      if (m_last !== (exp_q.size() == 1)) begin
        errors++;
        $display("FAIL drain_last: m_last=%b, required %b", m_last, (exp_q.size() == 1));
      end
      if (stalled) begin
        checks++;
        if (m_data !== held) begin
          errors++;
          $display("FAIL drain_hold: m_data=%h, required %h", m_data, held);
        end
      end
      hs = m_valid && m_ready;
      held = m_data;
      stalled = !hs;
      @(negedge clk);
      cyc++;
      if (hs) void'(exp_q.pop_front());
    end
    m_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_count: %0d beats left, required 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b busy=%b m_valid=%b, required 1 0 0", done, busy, m_valid);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({startAck, err_len, s_ready, m_valid, m_last, busy, done} !== 7'b0 ||
        m_data !== '0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: flags=%b m_data=%h state=%0d, required 0 0 0",
               {startAck, err_len, s_ready, m_valid, m_last, busy, done}, m_data, dbg_state);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || s_ready !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%b s_ready=%b m_valid=%b, required 0 0 0", busy, s_ready, m_valid);
    end
  endtask

  task automatic test_basic();
    int a0;
    int d0;
    @(negedge clk);
    a0 = ack_cnt;
    d0 = done_cnt;
    do_start(5'd8);
    fill_beats(8, 32'd0, 1'b0);
    drain_beats(1'b0);
    @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || ack_cnt - a0 != 1 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL basic_pulses: done=%b acks=%0d dones=%0d, required 0 1 1", done, ack_cnt - a0, done_cnt - d0);
    end
  endtask

  task automatic test_full_depth();
    @(negedge clk);
    do_start(5'd16);
    fill_beats(16, 32'h0000_0100, 1'b1);
    drain_beats(1'b1);
  endtask

  task automatic test_bad_len();
    logic [LEN_W-1:0] lens [3];
    int a0;
    lens[0] = 5'd0;
    lens[1] = 5'd17;
    lens[2] = 5'd31;
    @(negedge clk);
    a0 = ack_cnt;
    for (int i = 0; i < 3; i++) begin
      ex_start = 1'b1;
      cfg_len  = lens[i];
      @(negedge clk);
      ex_start = 1'b0;
      checks++;
      if (err_len !== 1'b1 || startAck !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL bad_len_pulse len=%0d: err_len=%b startAck=%b s_ready=%b busy=%b, required 1 0 0 0",
                 lens[i], err_len, startAck, s_ready, busy);
      end
      @(negedge clk);
      checks++;
      if (err_len !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL bad_len_after len=%0d: err_len=%b s_ready=%b busy=%b, required 0 0 0",
                 lens[i], err_len, s_ready, busy);
      end
    end
    #1;
    checks++;
    if (ack_cnt != a0) begin
      errors++;
      $display("FAIL bad_len_ack: %0d acks, required 0", ack_cnt - a0);
    end
  endtask

  task automatic test_ignore_start();
    int a0;
    int d0;
    @(negedge clk);
    a0 = ack_cnt;
    d0 = done_cnt;
    do_start(5'd8);
    ex_start = 1'b1;
    cfg_len  = 5'd3;
    fill_beats(8, 32'h0000_0200, 1'b0);
    drain_beats(1'b0);
    // ex_start was still high across the edge where done was high
    @(negedge clk);
    ex_start = 1'b0;
    checks++;
    if (startAck !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_on_done: startAck=%b busy=%b done=%b, required 0 0 0", startAck, busy, done);
    end
    #1;
    checks++;
    if (ack_cnt - a0 != 1 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL ignore_counts: acks=%0d dones=%0d, required 1 1", ack_cnt - a0, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    @(negedge clk);
    d0 = done_cnt;
    do_start(5'd8);
    fill_beats(3, 32'h0000_0300, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if ({startAck, err_len, s_ready, m_valid, m_last, busy, done} !== 7'b0 || m_data !== '0) begin
      errors++;
      $display("FAIL reset_mid: flags=%b m_data=%h, required 0 0",
               {startAck, err_len, s_ready, m_valid, m_last, busy, done}, m_data);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: dones=%0d busy=%b, required 0 0", done_cnt - d0, busy);
    end
    @(negedge clk);
    do_start(5'd2);
    fill_beats(2, 32'h0000_0400, 1'b0);
    drain_beats(1'b0);
  endtask

  task automatic test_single();
    @(negedge clk);
    do_start(5'd1);
    fill_beats(1, 32'hDEAD_BEEF, 1'b0);
    drain_beats(1'b0);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || m_last !== 1'b0) begin
      errors++;
      $display("FAIL single_after: done=%b m_last=%b, required 0 0", done, m_last);
    end
  endtask

  task automatic test_back_to_back();
    // a start presented on the cycle after done is accepted
    do_start(5'd3);
    fill_beats(3, 32'h0000_0500, 1'b0);
    drain_beats(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_full_depth();
    test_bad_len();
    test_ignore_start();
    test_reset_mid();
    test_single();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
